// File: rtl/commit_trace_sink.sv
// Commit trace sink: joins the address/data/PC debug commit streams into one record, updates a shadow
// register file and buffers records in a trace FIFO. Optional PC alignment check: COMMIT_SINK_PC_CHECK_EN.
module commit_trace_sink #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] debug_reg_addr_pyri,
    input  logic        debug_reg_addr_valid_pyri,
    output logic        debug_reg_addr_retry_pyro,
    input  logic [63:0] debug_reg_data_pyri,
    input  logic        debug_reg_data_valid_pyri,
    output logic        debug_reg_data_retry_pyro,
    input  logic [63:0] debug_committed_pc_pyri,
    input  logic        debug_committed_pc_valid_pyri,
    output logic        debug_committed_pc_retry_pyro,
    output logic [63:0] trace_pc_pyro,
    output logic [4:0]  trace_addr_pyro,
    output logic [63:0] trace_data_pyro,
    output logic        trace_valid_pyro,
    input  logic        trace_retry_pyri,
    input  logic [4:0]  rd_idx,
    output logic [63:0] rd_data,
    output logic [31:0] commit_count,
    output logic [1:0]  err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_C    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   EMPTY_C   = (AW+1)'(0);
    localparam logic [AW:0]   CNT_ONE_C = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE_C = AW'(1);

    // Only indices 1..31 with a clean upper half are architectural writes.
    function automatic logic addr_writable(input logic [63:0] a);
        return (a[63:5] == 59'd0) && (a[4:0] != 5'd0);
    endfunction

    function automatic logic addr_out_of_range(input logic [63:0] a);
        return a[63:5] != 59'd0;
    endfunction

    logic [63:0] pc_mem_r   [DEPTH];
    logic [4:0]  addr_mem_r [DEPTH];
    logic [63:0] data_mem_r [DEPTH];
    logic [63:0] shadow_r   [32];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [31:0]   commit_count_r;
    logic          range_err_r;
    logic          pc_err_s;
    logic          all_v_s;
    logic          accept_s;
    logic          pop_s;

    // Join decision: all three beats move together, blocked only by the current fill level.
    always_comb begin
        all_v_s  = debug_reg_addr_valid_pyri && debug_reg_data_valid_pyri && debug_committed_pc_valid_pyri;
        accept_s = all_v_s && (count_r < FULL_C);
        pop_s    = (count_r != EMPTY_C) && !trace_retry_pyri;
    end

    assign debug_reg_addr_retry_pyro     = !accept_s;
    assign debug_reg_data_retry_pyro     = !accept_s;
    assign debug_committed_pc_retry_pyro = !accept_s;

    // FIFO pointers and fill count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (accept_s) wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            else          wr_ptr_r <= wr_ptr_r;
            if (pop_s)    rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            else          rd_ptr_r <= rd_ptr_r;
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE_C;
                2'b01:   count_r <= count_r - CNT_ONE_C;
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO record storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]   <= 64'd0;
                addr_mem_r[i] <= 5'd0;
                data_mem_r[i] <= 64'd0;
            end
        end else if (accept_s) begin
            pc_mem_r[wr_ptr_r]   <= debug_committed_pc_pyri;
            addr_mem_r[wr_ptr_r] <= debug_reg_addr_pyri[4:0];
            data_mem_r[wr_ptr_r] <= debug_reg_data_pyri;
        end
    end

    // Shadow architectural register file.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                shadow_r[i] <= 64'd0;
            end
        end else if (accept_s && addr_writable(debug_reg_addr_pyri)) begin
            shadow_r[debug_reg_addr_pyri[4:0]] <= debug_reg_data_pyri;
        end
    end

    // Commit counter and sticky range error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            commit_count_r <= 32'd0;
            range_err_r    <= 1'b0;
        end else if (accept_s) begin
            commit_count_r <= commit_count_r + 32'd1;
            range_err_r    <= range_err_r | addr_out_of_range(debug_reg_addr_pyri);
        end
    end

`ifdef COMMIT_SINK_PC_CHECK_EN
    logic pc_err_r;

    // Sticky misaligned-PC flag; the record itself is unaffected.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_err_r <= 1'b0;
        end else if (accept_s && (debug_committed_pc_pyri[1:0] != 2'b00)) begin
            pc_err_r <= 1'b1;
        end
    end

    assign pc_err_s = pc_err_r;
`else
    assign pc_err_s = 1'b0;
`endif

    assign trace_pc_pyro    = pc_mem_r[rd_ptr_r];
    assign trace_addr_pyro  = addr_mem_r[rd_ptr_r];
    assign trace_data_pyro  = data_mem_r[rd_ptr_r];
    assign trace_valid_pyro = (count_r != EMPTY_C);
    assign rd_data          = (rd_idx == 5'd0) ? 64'd0 : shadow_r[rd_idx];
    assign commit_count     = commit_count_r;
    assign err              = {pc_err_s, range_err_r};

endmodule

// File: tb/tb_commit_trace_sink.sv
// Randomized bench for commit_trace_sink: a queue/array reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_commit_trace_sink;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] a_d, d_d, p_d;
    logic        a_v, d_v, p_v;
    logic        a_r, d_r, p_r;
    logic [63:0] t_pc, t_data;
    logic [4:0]  t_addr;
    logic        t_valid, t_retry;
    logic [4:0]  rd_idx;
    logic [63:0] rd_data;
    logic [31:0] commit_count;
    logic [1:0]  err;

    commit_trace_sink #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .debug_reg_addr_pyri(a_d), .debug_reg_addr_valid_pyri(a_v), .debug_reg_addr_retry_pyro(a_r),
        .debug_reg_data_pyri(d_d), .debug_reg_data_valid_pyri(d_v), .debug_reg_data_retry_pyro(d_r),
        .debug_committed_pc_pyri(p_d), .debug_committed_pc_valid_pyri(p_v), .debug_committed_pc_retry_pyro(p_r),
        .trace_pc_pyro(t_pc), .trace_addr_pyro(t_addr), .trace_data_pyro(t_data),
        .trace_valid_pyro(t_valid), .trace_retry_pyri(t_retry),
        .rd_idx(rd_idx), .rd_data(rd_data), .commit_count(commit_count), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [4:0]  addr;
        logic [63:0] data;
    } rec_t;

    rec_t        q[$];
    logic [63:0] shadow_m [32];
    logic [31:0] cnt_m;
    logic [1:0]  err_m;
    bit          last_acc;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 32; i++) shadow_m[i] = 64'd0;
        cnt_m = 32'd0;
        err_m = 2'b00;
    endtask

    task automatic compare();
        logic exp_retry;
        exp_retry = !(a_v && d_v && p_v && (q.size() < DEPTH));
        chk("addr_retry", a_r, exp_retry);
        chk("data_retry", d_r, exp_retry);
        chk("pc_retry", p_r, exp_retry);
        chk("trace_valid", t_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("trace_pc", t_pc, q[0].pc);
            chk("trace_addr", t_addr, q[0].addr);
            chk("trace_data", t_data, q[0].data);
        end
        chk("commit_count", commit_count, cnt_m);
        chk("err", err, err_m);
        chk("rd_data", rd_data, (rd_idx == 5'd0) ? 64'd0 : shadow_m[rd_idx]);
    endtask

    // One clock: check at the falling edge, then apply the reference rules for the rising edge.
    task automatic step();
        bit   acc_m, pop_m;
        rec_t r;
        @(negedge clk);
        compare();
        acc_m = a_v && d_v && p_v && (q.size() < DEPTH);
        pop_m = (q.size() != 0) && !t_retry;
        r.pc = p_d; r.addr = a_d[4:0]; r.data = d_d;
        @(posedge clk);
        #1;
        if (pop_m) void'(q.pop_front());
        if (acc_m) begin
            q.push_back(r);
            cnt_m = cnt_m + 32'd1;
            if (a_d > 64'd31) err_m[0] = 1'b1;
            else if (a_d != 64'd0) shadow_m[a_d] = d_d;
`ifdef COMMIT_SINK_PC_CHECK_EN
            if (p_d % 64'd4 != 64'd0) err_m[1] = 1'b1;
`endif
        end
        last_acc = acc_m;
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // Keep all three streams valid, replacing the beat once it has been consumed.
    task automatic feed();
        if (last_acc || !(a_v && d_v && p_v)) begin
            a_d = 64'($urandom_range(0, 31));
            d_d = rand64();
            p_d = rand64() & ~64'd3;
            a_v = 1'b1; d_v = 1'b1; p_v = 1'b1;
        end
    endtask

    task automatic idle();
        a_v = 1'b0; d_v = 1'b0; p_v = 1'b0;
    endtask

    task automatic set_beat(input logic [63:0] a, input logic [63:0] d, input logic [63:0] p);
        a_d = a; d_d = d; p_d = p;
        a_v = 1'b1; d_v = 1'b1; p_v = 1'b1;
    endtask

    initial begin
        logic [31:0] base;
        int          n;
        reset = 1'b0; t_retry = 1'b0; rd_idx = 5'd0; last_acc = 1'b0;
        a_d = 64'd0; d_d = 64'd0; p_d = 64'd0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_trace_valid", t_valid, 1'b0);
        chk("rst_retry", {a_r, d_r, p_r}, 3'b111);
        chk("rst_count", commit_count, 32'd0);
        chk("rst_err", err, 2'b00);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;

        // Join stall: PC stream missing for three cycles.
        a_d = 64'd5; a_v = 1'b1; d_d = 64'hDEAD; d_v = 1'b1; p_v = 1'b0; rd_idx = 5'd5;
        repeat (3) begin
            step();
            chk("stall_retry", a_r, 1'b1);
            chk("stall_count", commit_count, 32'd0);
        end
        p_d = 64'h1000; p_v = 1'b1;
        step();
        idle();
        #1;
        chk("join_valid", t_valid, 1'b1);
        chk("join_pc", t_pc, 64'h1000);
        chk("join_addr", t_addr, 5'd5);
        chk("join_data", t_data, 64'hDEAD);
        chk("join_rd5", rd_data, 64'hDEAD);
        chk("join_count", commit_count, 32'd1);

        // x0 is never written.
        set_beat(64'd0, 64'd7, 64'h1004);
        step();
        idle(); rd_idx = 5'd0;
        #1;
        chk("x0_rd", rd_data, 64'd0);
        chk("x0_err", err, 2'b00);

        // Out-of-range index: flagged, truncated, no shadow write.
        set_beat(64'h25, 64'h1234, 64'h2000);
        step();
        idle(); rd_idx = 5'd5;
        #1;
        chk("range_err", err, 2'b01);
        chk("range_addr", t_addr, 5'd5);
        chk("range_rd5", rd_data, 64'hDEAD);
        repeat (3) step();

        // FIFO full with downstream stalled: exactly DEPTH accepts.
        t_retry = 1'b1;
        repeat (6) begin
            feed();
            step();
        end
        chk("full_count", commit_count, 32'd7);
        chk("full_retry", a_r, 1'b1);
        t_retry = 1'b0;
        repeat (10) begin
            feed();
            step();
        end
        idle();
        repeat (6) step();

        // Steady push+pop at a fill level of two.
        t_retry = 1'b1;
        n = 0;
        for (int i = 0; i < 20 && n < 2; i++) begin
            feed();
            step();
            if (last_acc) n++;
        end
        chk("pp_fill", n, 2);
        t_retry = 1'b0;
        base = cnt_m;
        repeat (10) begin
            feed();
            step();
        end
        chk("pp_count", commit_count, base + 32'd10);
        idle();
        repeat (4) step();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if (last_acc) idle();
            if (!a_v && $urandom_range(0, 9) < 7) begin
                a_v = 1'b1;
                a_d = ($urandom_range(0, 7) == 0) ? rand64() : 64'($urandom_range(0, 31));
            end
            if (!d_v && $urandom_range(0, 9) < 7) begin
                d_v = 1'b1; d_d = rand64();
            end
            if (!p_v && $urandom_range(0, 9) < 7) begin
                p_v = 1'b1;
                p_d = ($urandom_range(0, 15) == 0) ? rand64() : (rand64() & ~64'd3);
            end
            t_retry = ($urandom_range(0, 3) == 0);
            rd_idx  = 5'($urandom_range(0, 31));
            step();
        end
        idle();
        t_retry = 1'b0;
        repeat (6) step();

        // Reset with three records buffered.
        t_retry = 1'b1;
        n = 0;
        for (int i = 0; i < 20 && n < 3; i++) begin
            feed();
            step();
            if (last_acc) n++;
        end
        idle();
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_valid", t_valid, 1'b0);
        chk("mid_rst_count", commit_count, 32'd0);
        chk("mid_rst_retry", {a_r, d_r, p_r}, 3'b111);
        chk("mid_rst_err", err, 2'b00);
        for (int i = 0; i < 32; i++) begin
            rd_idx = 5'(i);
            #1;
            chk("mid_rst_rd", rd_data, 64'd0);
        end
        model_reset();
        last_acc = 1'b0;
        @(negedge clk) reset = 1'b1;
        t_retry = 1'b0;
        @(posedge clk);
        #1;
        repeat (5) begin
            feed();
            step();
        end
        idle();
        repeat (6) step();

`ifdef COMMIT_SINK_PC_CHECK_EN
        set_beat(64'd3, 64'h55, 64'h1002);
        step();
        idle();
        #1;
        chk("pc_err", err[1], 1'b1);
        chk("pc_err_trace", t_pc, 64'h1002);
        repeat (3) step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
